// File: rtl/mxv_cmd_pkg.sv
// Shared constants and FSM state type for the host command parser that feeds
// the matrix-vector datapath.
package mxv_cmd_pkg;

  localparam logic [7:0] SOF        = 8'hFE;
  localparam logic [7:0] EOF        = 8'hEF;
  localparam logic [7:0] CMD_SET_N  = 8'h01;
  localparam logic [7:0] CMD_START  = 8'h03;
  localparam logic [7:0] CMD_MATRIX = 8'h04;
  localparam logic [7:0] CMD_VECTOR = 8'h05;

  localparam int MAX_N_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_CMD     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_TAIL    = 3'd4
  } state_t;

endpackage

// File: rtl/uart_cmd_decoder_start_stretcher.sv
// Holds the start request high for START_HOLD cycles so the slow MxV clock
// domain is guaranteed to see it; re-triggers while busy are ignored.
module start_stretcher #(
  parameter int START_HOLD = 10_000
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  output logic start,
  output logic busy
);

  localparam int CW = $clog2(START_HOLD + 1);

  logic [CW-1:0] r_count;
  logic          r_start;

  // r_count holds the remaining high cycles after the current one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_start <= 1'b0;
      r_count <= '0;
    end else if (trigger && !r_start) begin
      r_start <= 1'b1;
      r_count <= CW'(START_HOLD - 1);
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end else begin
      r_start <= 1'b0;
    end
  end

  assign start = r_start;
  assign busy  = r_start;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses framed host commands (FE, L, CMD, payload, EF) from the UART receiver
// and drives the matrix FIFO, vector, matrix length and start of the MxV engine.
module uart_cmd_decoder
  import mxv_cmd_pkg::*;
#(
  parameter int WORD_LENGTH    = 8,
  parameter int MAX_N          = MAX_N_DEFAULT,
  parameter int START_HOLD     = 10_000,
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WORD_LENGTH-1:0]       rx_data,
  input  logic                         rx_valid,
  output logic                         clear_interrupt,
  output logic [WORD_LENGTH-1:0]       fifo_value,
  output logic                         fifo_push,
  output logic [MAX_N*WORD_LENGTH-1:0] vector,
  output logic [31:0]                  matrix_length,
  output logic                         start,
  output logic                         cmd_done,
  output logic                         frame_error,
  output state_t                       o_dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [7:0] MAX_N_B = 8'(MAX_N);

  state_t                       r_state;
  logic [7:0]                   r_len;
  logic [7:0]                   r_cmd;
  logic [7:0]                   r_remain;
  logic [IW-1:0]                r_idx;
  logic [7:0]                   r_new_n;
  logic [MAX_N*WORD_LENGTH-1:0] r_shadow;
  logic [TW-1:0]                r_timeout;

  logic       w_accept;
  logic       w_busy;
  logic       w_start_trig;
  logic       w_cmd_ok;
  logic [7:0] w_n8;
  logic [7:0] w_n_sq;

  // A byte is taken only when the interrupt is not already being cleared;
  // the level is held by the UART through the clear cycle.
  assign w_accept = rx_valid && !clear_interrupt;

  assign w_n8   = matrix_length[7:0];
  assign w_n_sq = w_n8 * w_n8;

  // Required L is checked against the currently committed N.
  always_comb begin
    w_cmd_ok = 1'b0;
    case (rx_data)
      CMD_SET_N:  w_cmd_ok = (r_len == 8'd2);
      CMD_START:  w_cmd_ok = (r_len == 8'd1) && !w_busy;
      CMD_MATRIX: w_cmd_ok = (r_len == w_n_sq + 8'd1);
      CMD_VECTOR: w_cmd_ok = (r_len == w_n8 + 8'd1);
      default:    w_cmd_ok = 1'b0;
    endcase
  end

  assign w_start_trig = w_accept && (r_state == ST_TAIL) &&
                        (rx_data == EOF) && (r_cmd == CMD_START);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_len           <= '0;
      r_cmd           <= '0;
      r_remain        <= '0;
      r_idx           <= '0;
      r_new_n         <= '0;
      r_shadow        <= '0;
      r_timeout       <= '0;
      clear_interrupt <= 1'b0;
      fifo_push       <= 1'b0;
      fifo_value      <= '0;
      vector          <= '0;
      matrix_length   <= 32'(MAX_N);
      cmd_done        <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      clear_interrupt <= w_accept;
      fifo_push       <= 1'b0;
      cmd_done        <= 1'b0;
      frame_error     <= 1'b0;

      // Inter-byte timeout only runs while a frame is open.
      if (w_accept) begin
        r_timeout <= '0;
      end else if (r_state != ST_IDLE) begin
        if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
          frame_error <= 1'b1;
          r_state     <= ST_IDLE;
          r_timeout   <= '0;
        end else begin
          r_timeout <= r_timeout + 1'b1;
        end
      end

      if (w_accept) begin
        case (r_state)
          ST_IDLE: begin
            if (rx_data == SOF) r_state <= ST_LEN;
          end
          ST_LEN: begin
            r_len   <= rx_data;
            r_state <= ST_CMD;
          end
          ST_CMD: begin
            r_cmd    <= rx_data;
            r_remain <= r_len - 8'd1;
            r_idx    <= '0;
            r_shadow <= '0;
            if (!w_cmd_ok) begin
              frame_error <= 1'b1;
              r_state     <= ST_IDLE;
            end else if (r_len == 8'd1) begin
              r_state <= ST_TAIL;
            end else begin
              r_state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            r_remain <= r_remain - 8'd1;
            r_idx    <= r_idx + 1'b1;
            if (r_remain == 8'd1) r_state <= ST_TAIL;
            case (r_cmd)
              CMD_SET_N: begin
                if ((rx_data == 8'd0) || (rx_data > MAX_N_B)) begin
                  frame_error <= 1'b1;
                  r_state     <= ST_IDLE;
                end else begin
                  r_new_n <= rx_data;
                end
              end
              CMD_MATRIX: begin
                fifo_push  <= 1'b1;
                fifo_value <= rx_data;
              end
              CMD_VECTOR: begin
                r_shadow[r_idx*WORD_LENGTH +: WORD_LENGTH] <= rx_data;
              end
              default: ;
            endcase
          end
          ST_TAIL: begin
            r_state <= ST_IDLE;
            if (rx_data != EOF) begin
              frame_error <= 1'b1;
            end else begin
              cmd_done <= 1'b1;
              case (r_cmd)
                CMD_SET_N:  matrix_length <= {24'd0, r_new_n};
                CMD_VECTOR: vector        <= r_shadow;
                default: ;
              endcase
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  start_stretcher #(
    .START_HOLD (START_HOLD)
  ) u_start_stretcher (
    .clk     (clk),
    .reset   (reset),
    .trigger (w_start_trig),
    .start   (start),
    .busy    (w_busy)
  );

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: a table of frames with expected
// committed state, plus hand-written START, timeout and reset sequences.
module tb_uart_cmd_decoder;
  import mxv_cmd_pkg::*;

  localparam int HOLD = 10_000;
  localparam int TMO  = 300;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        clear_interrupt;
  logic [7:0]  fifo_value;
  logic        fifo_push;
  logic [63:0] vector;
  logic [31:0] matrix_length;
  logic        start;
  logic        cmd_done;
  logic        frame_error;
  state_t      dbg_state;

  always #10 clk = ~clk;

  uart_cmd_decoder #(
    .WORD_LENGTH    (8),
    .MAX_N          (8),
    .START_HOLD     (HOLD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .clear_interrupt (clear_interrupt),
    .fifo_value      (fifo_value),
    .fifo_push       (fifo_push),
    .vector          (vector),
    .matrix_length   (matrix_length),
    .start           (start),
    .cmd_done        (cmd_done),
    .frame_error     (frame_error),
    .o_dbg_state     (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // scoreboard for FIFO pushes
  logic [7:0] exp_q[$];
  int done_cnt = 0, err_cnt = 0, clr_cnt = 0, hi_cnt = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_done) done_cnt++;
    if (frame_error) err_cnt++;
    if (clear_interrupt) clr_cnt++;
    if (start) hi_cnt++;
    if (fifo_push) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL push_extra actual=%h expected=none", fifo_value);
      end else begin
        check("push_value", {56'd0, fifo_value}, {56'd0, exp_q.pop_front()});
      end
    end
  end

  // driver
  int   last_acc = 0;
  logic snap_start, snap_done, snap_err;

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 last_acc = cyc;
    @(negedge clk);
    snap_start = start;
    snap_done  = cmd_done;
    snap_err   = frame_error;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [95:0] b;
    int          n;
    logic [31:0] exp_len;
    logic [63:0] exp_vec;
    int          exp_done;
    int          exp_err;
    int          n_push;
  } vec_t;

  function automatic vec_t mk(logic [95:0] b, int n, logic [31:0] l, logic [63:0] v,
                              int d, int e, int p);
    vec_t t;
    t.b = b; t.n = n; t.exp_len = l; t.exp_vec = v;
    t.exp_done = d; t.exp_err = e; t.n_push = p;
    return t;
  endfunction

  localparam int NV = 20;
  vec_t tv[NV];

  initial begin
    int d0, e0, c0, h0, guard, el;
    logic [7:0] bt;

    tv[0]  = mk({40'hFE_02_01_03_EF, 56'h0}, 5, 3, 64'h0, 1, 0, 0);
    tv[1]  = mk({56'hFE_04_05_0A_0B_0C_EF, 40'h0}, 7, 3, 64'h0C0B0A, 1, 0, 0);
    tv[2]  = mk({40'hFE_02_01_02_EF, 56'h0}, 5, 2, 64'h0C0B0A, 1, 0, 0);
    tv[3]  = mk({64'hFE_05_04_01_02_03_04_EF, 32'h0}, 8, 2, 64'h0C0B0A, 1, 0, 4);
    tv[4]  = mk({40'hFE_02_01_09_EF, 56'h0}, 5, 2, 64'h0C0B0A, 0, 1, 0);
    tv[5]  = mk({40'hFE_03_01_02_EF, 56'h0}, 5, 2, 64'h0C0B0A, 0, 1, 0);
    tv[6]  = mk({32'hFE_01_03_AA, 64'h0}, 4, 2, 64'h0C0B0A, 0, 1, 0);
    tv[7]  = mk({56'h55_EF_FE_02_01_00_EF, 40'h0}, 7, 2, 64'h0C0B0A, 0, 1, 0);
    tv[8]  = mk({48'hFE_03_05_11_22_EF, 48'h0}, 6, 2, 64'h2211, 1, 0, 0);
    tv[9]  = mk({40'hFE_02_05_33_EF, 56'h0}, 5, 2, 64'h2211, 0, 1, 0);
    tv[10] = mk({40'hFE_02_07_00_EF, 56'h0}, 5, 2, 64'h2211, 0, 1, 0);
    tv[11] = mk({40'hFE_02_01_08_EF, 56'h0}, 5, 8, 64'h2211, 1, 0, 0);
    tv[12] = mk(96'hFE_09_05_FE_01_02_03_04_05_06_07_EF, 12, 8, 64'h07060504030201FE, 1, 0, 0);
    tv[13] = mk({48'hFE_03_04_AA_BB_EF, 48'h0}, 6, 8, 64'h07060504030201FE, 0, 1, 0);
    tv[14] = mk({40'hFE_02_01_02_EF, 56'h0}, 5, 2, 64'h07060504030201FE, 1, 0, 0);
    tv[15] = mk({64'hFE_05_04_09_08_07_06_AA, 32'h0}, 8, 2, 64'h07060504030201FE, 0, 1, 4);
    tv[16] = mk({40'hFE_02_01_01_EF, 56'h0}, 5, 1, 64'h07060504030201FE, 1, 0, 0);
    tv[17] = mk({40'hFE_02_05_5A_EF, 56'h0}, 5, 1, 64'h5A, 1, 0, 0);
    tv[18] = mk({40'hFE_02_04_77_EF, 56'h0}, 5, 1, 64'h5A, 1, 0, 1);
    tv[19] = mk({32'hFE_00_03_EF, 64'h0}, 4, 1, 64'h5A, 0, 1, 0);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_len", {32'd0, matrix_length}, 64'd8);
    check("rst_vec", vector, 64'd0);
    check("rst_outs", {56'd0, clear_interrupt, fifo_push, start, cmd_done, frame_error, 3'b0}, 64'd0);
    check("rst_fifo_value", {56'd0, fifo_value}, 64'd0);
    check("rst_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    @(posedge clk);
    #1 reset = 1'b1;
    idle(2);

    // table-driven frames
    for (int i = 0; i < NV; i++) begin
      d0 = done_cnt; e0 = err_cnt; c0 = clr_cnt;
      for (int k = 0; k < tv[i].n_push; k++) begin
        bt = tv[i].b[95-8*(3+k) -: 8];
        exp_q.push_back(bt);
      end
      for (int k = 0; k < tv[i].n; k++) begin
        bt = tv[i].b[95-8*k -: 8];
        send_byte(bt);
      end
      idle(3);
      check($sformatf("v%0d_len", i), {32'd0, matrix_length}, {32'd0, tv[i].exp_len});
      check($sformatf("v%0d_vec", i), vector, tv[i].exp_vec);
      check($sformatf("v%0d_done", i), 64'(done_cnt - d0), 64'(tv[i].exp_done));
      check($sformatf("v%0d_err", i), 64'(err_cnt - e0), 64'(tv[i].exp_err));
      check($sformatf("v%0d_clr", i), 64'(clr_cnt - c0), 64'(tv[i].n));
      check($sformatf("v%0d_push_left", i), 64'(exp_q.size()), 64'd0);
      check($sformatf("v%0d_start", i), {63'd0, start}, 64'd0);
      exp_q.delete();
    end

    // START hold, with a rejected second START during the hold
    d0 = done_cnt; e0 = err_cnt; h0 = hi_cnt;
    send_byte(8'hFE); send_byte(8'h01); send_byte(8'h03);
    check("start_low_before_eof", {63'd0, start}, 64'd0);
    send_byte(8'hEF);
    check("start_rise_t1", {63'd0, snap_start}, 64'd1);
    check("start_done_t1", {63'd0, snap_done}, 64'd1);
    idle(1000);
    send_byte(8'hFE); send_byte(8'h01); send_byte(8'h03); send_byte(8'hEF);
    idle(3);
    check("start_busy_err", 64'(err_cnt - e0), 64'd1);
    check("start_busy_done", 64'(done_cnt - d0), 64'd1);
    guard = 0;
    while (start && guard < HOLD + 2000) begin
      @(negedge clk);
      guard++;
    end
    check("start_fell", {63'd0, start}, 64'd0);
    idle(2);
    check("start_hold_cycles", 64'(hi_cnt - h0), 64'(HOLD));

    // timeout expiry after FE 02
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hFE); send_byte(8'h02);
    guard = 0;
    while (!frame_error && guard < TMO + 50) begin
      @(negedge clk);
      guard++;
    end
    el = cyc - last_acc;
    check("tmo_seen", {63'd0, frame_error}, 64'd1);
    check("tmo_window", {63'd0, (el >= TMO - 2) && (el <= TMO + 2)}, 64'd1);
    idle(3);
    check("tmo_err_cnt", 64'(err_cnt - e0), 64'd1);
    check("tmo_len_kept", {32'd0, matrix_length}, 64'd1);
    check("tmo_state_idle", {61'd0, dbg_state}, {61'd0, ST_IDLE});

    // slow but in-time bytes must not time out
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hFE); send_byte(8'h02); send_byte(8'h01);
    idle(TMO - 40);
    send_byte(8'h04);
    idle(TMO - 40);
    send_byte(8'hEF);
    idle(3);
    check("slow_len", {32'd0, matrix_length}, 64'd4);
    check("slow_err", 64'(err_cnt - e0), 64'd0);
    check("slow_done", 64'(done_cnt - d0), 64'd1);

    // reset mid-VECTOR frame during a START hold
    send_byte(8'hFE); send_byte(8'h01); send_byte(8'h03); send_byte(8'hEF);
    idle(50);
    check("rst_pre_start", {63'd0, start}, 64'd1);
    send_byte(8'hFE); send_byte(8'h05); send_byte(8'h05); send_byte(8'hAA); send_byte(8'hBB);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_len", {32'd0, matrix_length}, 64'd8);
    check("mid_rst_vec", vector, 64'd0);
    check("mid_rst_start", {63'd0, start}, 64'd0);
    check("mid_rst_fifo_value", {56'd0, fifo_value}, 64'd0);
    check("mid_rst_pulses", {61'd0, clear_interrupt, cmd_done, frame_error}, 64'd0);
    check("mid_rst_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    @(posedge clk);
    #1 reset = 1'b1;
    h0 = hi_cnt;
    idle(5);
    check("post_rst_start_low", 64'(hi_cnt - h0), 64'd0);
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hFE); send_byte(8'h09); send_byte(8'h05);
    for (int k = 1; k <= 8; k++) send_byte(8'(k));
    send_byte(8'hEF);
    idle(3);
    check("post_rst_vec", vector, 64'h0807060504030201);
    check("post_rst_done", 64'(done_cnt - d0), 64'd1);
    check("post_rst_err", 64'(err_cnt - e0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
